// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg
// Shared encodings for the multicycle MIPS control sequencer.
//   state_t      : sequencer state, 4 bits, FETCH = 0
//   OP_* / FUNCT_: instruction fields the sequencer dispatches on
//   ALU_*        : alu_op codes understood by AluControlUint
//   SRCB_*       : ALU B input select codes
//   PCSRC_*      : next-PC select codes
//   MTR_*        : register write data select codes
//   RDST_*       : write register select codes
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        JR        = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13,
        LUI       = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FUNCT_JR = 6'd8;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_XOR   = 3'd5;
    localparam logic [2:0] ALU_SLT   = 3'd6;

    localparam logic [2:0] SRCB_B        = 3'd0;
    localparam logic [2:0] SRCB_FOUR     = 3'd1;
    localparam logic [2:0] SRCB_SIMM     = 3'd2;
    localparam logic [2:0] SRCB_SIMM_SH2 = 3'd3;
    localparam logic [2:0] SRCB_ZIMM     = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] MTR_ALUOUT = 2'd0;
    localparam logic [1:0] MTR_MDR    = 2'd1;
    localparam logic [1:0] MTR_PC     = 2'd2;
    localparam logic [1:0] MTR_LUI    = 2'd3;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    // State that DECODE moves to for a given instruction. Returning FETCH
    // means the opcode is unsupported.
    function automatic state_t decode_dispatch(input logic [5:0] opcode,
                                               input logic [5:0] funct);
        state_t target;
        target = FETCH;
        case (opcode)
            OP_RTYPE: target = (funct == FUNCT_JR) ? JR : R_EXEC;
            OP_LW, OP_SW: target = MEM_ADDR;
            OP_BEQ, OP_BNE: target = BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: target = I_EXEC;
            OP_LUI: target = LUI;
            OP_J: target = JUMP;
            OP_JAL: target = JAL;
            default: target = FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore control sequencer for the multicycle MIPS datapath. One memory port
// is shared by fetch and data access; mem_ready stretches FETCH, MEM_READ
// and MEM_WRITE until the access completes.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   opcode, funct         : instruction register fields
//   mem_ready             : memory access completes this cycle
//   pc_write, pc_write_cond, branch_ne, pc_source : PC update controls
//   i_or_d, mem_read, mem_write, ir_write         : memory port controls
//   reg_write, reg_dst, mem_to_reg                : register file controls
//   alu_src_a, alu_src_b, alu_op                  : ALU controls
//   instr_done, illegal   : end-of-instruction and bad-opcode pulses
//   state                 : current state for debug
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [2:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_next;

    assign state = state_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        state_next = state_q;
        case (state_q)
            FETCH:     state_next = mem_ready ? DECODE : FETCH;
            DECODE:    state_next = decode_dispatch(opcode, funct);
            MEM_ADDR:  state_next = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  state_next = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: state_next = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    state_next = R_WB;
            I_EXEC:    state_next = I_WB;
            default:   state_next = FETCH;
        endcase
    end

    // Output decode. Everything is zero while reset is high so no write
    // strobe can reach the datapath. MEM_WRITE only flags instr_done on the
    // cycle the store is accepted, keeping it a single-cycle pulse.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = RDST_RT;
        mem_to_reg    = MTR_ALUOUT;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = SRCB_SIMM_SH2;
                    illegal   = (decode_dispatch(opcode, funct) == FETCH);
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SIMM;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MTR_MDR;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = RDST_RD;
                    instr_done = 1'b1;
                end
                JR: begin
                    pc_source  = PCSRC_REG;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                I_EXEC: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_SLTI: begin alu_src_b = SRCB_SIMM; alu_op = ALU_SLT; end
                        OP_ANDI: begin alu_src_b = SRCB_ZIMM; alu_op = ALU_AND; end
                        OP_ORI:  begin alu_src_b = SRCB_ZIMM; alu_op = ALU_OR;  end
                        OP_XORI: begin alu_src_b = SRCB_ZIMM; alu_op = ALU_XOR; end
                        default: begin alu_src_b = SRCB_SIMM; alu_op = ALU_ADD; end
                    endcase
                end
                I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    branch_ne     = (opcode == OP_BNE);
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_source  = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                JAL: begin
                    pc_source  = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = RDST_RA;
                    mem_to_reg = MTR_PC;
                    instr_done = 1'b1;
                end
                LUI: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MTR_LUI;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Scoreboard bench for the multicycle control sequencer: each cycle the
// stimulus side pushes the control word it expects, and a negedge monitor
// pops and compares it against the DUT outputs.
module tb_mips_multicycle_ctrl;
    import mips_mc_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        string tag;
        ctrl_t exp;
    } sb_entry_t;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, i_or_d;
    logic       mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, pc_source;
    logic [2:0] alu_src_b, alu_op;
    logic       instr_done, illegal;
    logic [3:0] state;

    ctrl_t     observed;
    sb_entry_t sb[$];
    int        assert_count = 0;
    int        fail_count   = 0;

    mips_multicycle_ctrl dut (
        .clock(clock),
        .reset(reset),
        .opcode(opcode),
        .funct(funct),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .reg_write(reg_write),
        .alu_src_a(alu_src_a),
        .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b),
        .alu_op(alu_op),
        .pc_source(pc_source),
        .instr_done(instr_done),
        .illegal(illegal),
        .state(state)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign observed = '{pc_write, pc_write_cond, branch_ne, i_or_d, mem_read,
                        mem_write, ir_write, reg_write, alu_src_a, reg_dst,
                        mem_to_reg, alu_src_b, alu_op, pc_source, instr_done,
                        illegal, state};

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: compare the DUT control word mid-cycle against the queue.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            sb_entry_t ent;
            ent = sb.pop_front();
            checkOutput(ent.tag, 32'(observed), 32'(ent.exp));
        end
    end

    // One cycle of stimulus: drive inputs just after the edge and push the
    // control word expected for this cycle.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic [5:0] op, input logic [5:0] fn,
                                 input logic rdy, input ctrl_t exp);
        sb_entry_t ent;
        @(posedge clock);
        #1;
        reset     = rst;
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        ent.tag   = tag;
        ent.exp   = exp;
        sb.push_back(ent);
    endtask

    function automatic ctrl_t blank(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        c.state = st;
        return c;
    endfunction

    function automatic ctrl_t fetch_vec(input logic rdy);
        ctrl_t c;
        c = blank(4'd0);
        c.mem_read  = 1'b1;
        c.alu_src_b = 3'd1;
        c.ir_write  = rdy;
        c.pc_write  = rdy;
        return c;
    endfunction

    function automatic ctrl_t decode_vec();
        ctrl_t c;
        c = blank(4'd1);
        c.alu_src_b = 3'd3;
        return c;
    endfunction

    ctrl_t e;

    initial begin
        reset     = 1'b1;
        opcode    = 6'd0;
        funct     = 6'd0;
        mem_ready = 1'b1;

        // Power-on reset, then lw stalled in MEM_READ and reset mid-way.
        applyStimulus("por", 1'b1, 6'd35, 6'd0, 1'b1, blank(FETCH));
        applyStimulus("lw_rst_fetch", 1'b0, 6'd35, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("lw_rst_decode", 1'b0, 6'd35, 6'd0, 1'b1, decode_vec());
        e = blank(MEM_ADDR); e.alu_src_a = 1; e.alu_src_b = 3'd2;
        applyStimulus("lw_rst_addr", 1'b0, 6'd35, 6'd0, 1'b1, e);
        e = blank(MEM_READ); e.mem_read = 1; e.i_or_d = 1;
        applyStimulus("lw_rst_read", 1'b0, 6'd35, 6'd0, 1'b0, e);
        applyStimulus("rst_cyc1", 1'b1, 6'd35, 6'd0, 1'b0, blank(MEM_READ));
        applyStimulus("rst_cyc2", 1'b1, 6'd35, 6'd0, 1'b1, blank(FETCH));
        applyStimulus("rst_cyc3", 1'b1, 6'd35, 6'd0, 1'b1, blank(FETCH));

        // R-type add: 4 cycles, with a fetch wait state first.
        applyStimulus("add_fetch_wait", 1'b0, 6'd0, 6'd32, 1'b0, fetch_vec(1'b0));
        applyStimulus("add_fetch", 1'b0, 6'd0, 6'd32, 1'b1, fetch_vec(1'b1));
        applyStimulus("add_decode", 1'b0, 6'd0, 6'd32, 1'b1, decode_vec());
        e = blank(R_EXEC); e.alu_src_a = 1; e.alu_op = 3'd2;
        applyStimulus("add_exec", 1'b0, 6'd0, 6'd32, 1'b1, e);
        e = blank(R_WB); e.reg_write = 1; e.reg_dst = 2'd1; e.instr_done = 1;
        applyStimulus("add_wb", 1'b0, 6'd0, 6'd32, 1'b1, e);

        // lw with two wait states in MEM_READ: 7 cycles.
        applyStimulus("lw_fetch", 1'b0, 6'd35, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("lw_decode", 1'b0, 6'd35, 6'd0, 1'b1, decode_vec());
        e = blank(MEM_ADDR); e.alu_src_a = 1; e.alu_src_b = 3'd2;
        applyStimulus("lw_addr", 1'b0, 6'd35, 6'd0, 1'b1, e);
        e = blank(MEM_READ); e.mem_read = 1; e.i_or_d = 1;
        applyStimulus("lw_wait1", 1'b0, 6'd35, 6'd0, 1'b0, e);
        applyStimulus("lw_wait2", 1'b0, 6'd35, 6'd0, 1'b0, e);
        applyStimulus("lw_read", 1'b0, 6'd35, 6'd0, 1'b1, e);
        e = blank(MEM_WB); e.reg_write = 1; e.mem_to_reg = 2'd1; e.instr_done = 1;
        applyStimulus("lw_wb", 1'b0, 6'd35, 6'd0, 1'b1, e);

        // sw with one wait state in MEM_WRITE.
        applyStimulus("sw_fetch", 1'b0, 6'd43, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("sw_decode", 1'b0, 6'd43, 6'd0, 1'b1, decode_vec());
        e = blank(MEM_ADDR); e.alu_src_a = 1; e.alu_src_b = 3'd2;
        applyStimulus("sw_addr", 1'b0, 6'd43, 6'd0, 1'b1, e);
        e = blank(MEM_WRITE); e.mem_write = 1; e.i_or_d = 1;
        applyStimulus("sw_wait", 1'b0, 6'd43, 6'd0, 1'b0, e);
        e.instr_done = 1;
        applyStimulus("sw_write", 1'b0, 6'd43, 6'd0, 1'b1, e);

        // bne and beq: 3 cycles each.
        applyStimulus("bne_fetch", 1'b0, 6'd5, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("bne_decode", 1'b0, 6'd5, 6'd0, 1'b1, decode_vec());
        e = blank(BRANCH); e.alu_src_a = 1; e.alu_op = 3'd1; e.pc_write_cond = 1;
        e.pc_source = 2'd1; e.branch_ne = 1; e.instr_done = 1;
        applyStimulus("bne_branch", 1'b0, 6'd5, 6'd0, 1'b1, e);
        applyStimulus("beq_fetch", 1'b0, 6'd4, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("beq_decode", 1'b0, 6'd4, 6'd0, 1'b1, decode_vec());
        e.branch_ne = 0;
        applyStimulus("beq_branch", 1'b0, 6'd4, 6'd0, 1'b1, e);

        // jal, jr, j.
        applyStimulus("jal_fetch", 1'b0, 6'd3, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("jal_decode", 1'b0, 6'd3, 6'd0, 1'b1, decode_vec());
        e = blank(JAL); e.pc_source = 2'd2; e.pc_write = 1; e.reg_write = 1;
        e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; e.instr_done = 1;
        applyStimulus("jal_exec", 1'b0, 6'd3, 6'd0, 1'b1, e);
        applyStimulus("jr_fetch", 1'b0, 6'd0, 6'd8, 1'b1, fetch_vec(1'b1));
        applyStimulus("jr_decode", 1'b0, 6'd0, 6'd8, 1'b1, decode_vec());
        e = blank(JR); e.pc_source = 2'd3; e.pc_write = 1; e.instr_done = 1;
        applyStimulus("jr_exec", 1'b0, 6'd0, 6'd8, 1'b1, e);
        applyStimulus("j_fetch", 1'b0, 6'd2, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("j_decode", 1'b0, 6'd2, 6'd0, 1'b1, decode_vec());
        e = blank(JUMP); e.pc_source = 2'd2; e.pc_write = 1; e.instr_done = 1;
        applyStimulus("j_exec", 1'b0, 6'd2, 6'd0, 1'b1, e);

        // Illegal opcode 63, then ori with mem_ready low outside memory states.
        applyStimulus("ill_fetch", 1'b0, 6'd63, 6'd0, 1'b1, fetch_vec(1'b1));
        e = decode_vec(); e.illegal = 1;
        applyStimulus("ill_decode", 1'b0, 6'd63, 6'd0, 1'b1, e);
        applyStimulus("ori_fetch", 1'b0, 6'd13, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("ori_decode", 1'b0, 6'd13, 6'd0, 1'b0, decode_vec());
        e = blank(I_EXEC); e.alu_src_a = 1; e.alu_src_b = 3'd4; e.alu_op = 3'd3;
        applyStimulus("ori_exec", 1'b0, 6'd13, 6'd0, 1'b0, e);
        e = blank(I_WB); e.reg_write = 1; e.instr_done = 1;
        applyStimulus("ori_wb", 1'b0, 6'd13, 6'd0, 1'b0, e);

        // slti and lui.
        applyStimulus("slti_fetch", 1'b0, 6'd10, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("slti_decode", 1'b0, 6'd10, 6'd0, 1'b1, decode_vec());
        e = blank(I_EXEC); e.alu_src_a = 1; e.alu_src_b = 3'd2; e.alu_op = 3'd6;
        applyStimulus("slti_exec", 1'b0, 6'd10, 6'd0, 1'b1, e);
        e = blank(I_WB); e.reg_write = 1; e.instr_done = 1;
        applyStimulus("slti_wb", 1'b0, 6'd10, 6'd0, 1'b1, e);
        applyStimulus("lui_fetch", 1'b0, 6'd15, 6'd0, 1'b1, fetch_vec(1'b1));
        applyStimulus("lui_decode", 1'b0, 6'd15, 6'd0, 1'b1, decode_vec());
        e = blank(LUI); e.reg_write = 1; e.mem_to_reg = 2'd3; e.instr_done = 1;
        applyStimulus("lui_exec", 1'b0, 6'd15, 6'd0, 1'b1, e);
        applyStimulus("final_fetch", 1'b0, 6'd0, 6'd0, 1'b0, fetch_vec(1'b0));

        @(negedge clock);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
